// File: rtl/ysyx_23060061_pkg.sv
// Shared definitions for ysyx_23060061 bus responders.
//   RESP_*     : read-response codes returned on rresp
//   RESET_PC   : byte address the core fetches first; default base of the instruction store
//   ST_*       : responder FSM state encoding (IDLE / WAIT / RESP)
//   addr_resp(): classifies a byte address against a [base, limit) window
package ysyx_23060061_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Misalignment wins over range. The window check is done in 33 bits so a
  // window that ends exactly at 2^32 cannot wrap around to accept low addresses.
  function automatic logic [1:0] addr_resp(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] limit);
    logic [1:0] resp;
    if (addr[1:0] != 2'b00) begin
      resp = RESP_SLVERR;
    end else if (({1'b0, addr} < {1'b0, base}) || ({1'b0, addr} >= limit)) begin
      resp = RESP_DECERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/ysyx_23060061_sram_array.sv
// Word-addressed instruction store: one synchronous write port, one registered
// read port. Read data only changes on a cycle where rd_en is high, so the
// output holds the last word read for as long as the caller needs it.
// The contents start undefined and are filled through the write port.
//   clk      : clock
//   wr_en    : write strobe, wr_data stored at wr_idx on the rising edge
//   wr_idx   : write word index
//   wr_data  : write word
//   rd_en    : read strobe, rd_data updated from rd_idx on the rising edge
//   rd_idx   : read word index
//   rd_data  : registered read word
module ysyx_23060061_sram_array #(
  parameter int    DEPTH     = 4096,
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/ysyx_23060061_inst_sram.sv
// Instruction-memory responder for the IFU. Accepts one fetch at a time on the
// AR channel, waits LAT cycles to model SRAM access time, then presents the
// word on the R channel until the IFU takes it. A side port preloads the image.
//   clk, rst          : clock, synchronous active-high reset
//   araddr/arvalid    : fetch byte address and request valid (IFU holds until accepted)
//   arready           : high only in IDLE
//   rdata/rresp/rvalid: response word, status (OKAY/SLVERR/DECERR), response valid
//   rready            : IFU accepts the response
//   ld_en/ld_addr/ld_data : preload write, honoured only in IDLE for good addresses
module ysyx_23060061_inst_sram
  import ysyx_23060061_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int          DEPTH     = 4096,
  parameter int          LAT       = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg;
  logic [1:0]    rresp_reg;
  logic          rvalid_reg;
  logic          arready_reg;

  logic          ar_hs, r_hs, wait_done;
  logic [1:0]    fetch_resp, ld_resp;
  logic          wr_en, rd_en;
  logic [31:0]   ld_off, rd_off;
  logic [31:0]   array_rdata;

  assign ar_hs     = arvalid && arready_reg;
  assign r_hs      = rvalid_reg && rready;
  assign wait_done = (state_reg == ST_WAIT) && (cnt_reg == CNT_LAST);

  assign fetch_resp = addr_resp(addr_reg, BASE_ADDR, LIMIT);
  assign ld_resp    = addr_resp(ld_addr, BASE_ADDR, LIMIT);

  // Word offsets from the base; only the index bits reach the array.
  assign ld_off = ld_addr - BASE_ADDR;
  assign rd_off = addr_reg - BASE_ADDR;

  logic unused_off;
  assign unused_off = ^{ld_off[31:AW+2], ld_off[1:0], rd_off[31:AW+2], rd_off[1:0]};

  // A preload and an AR handshake in the same IDLE cycle both take effect on
  // that edge; the array read happens later at WAIT->RESP, so the fetch sees
  // the freshly written word.
  assign wr_en = !rst && (state_reg == ST_IDLE) && ld_en && (ld_resp == RESP_OKAY);
  assign rd_en = wait_done && (fetch_resp == RESP_OKAY);

  ysyx_23060061_sram_array #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (ld_off[AW+1:2]),
    .wr_data(ld_data),
    .rd_en  (rd_en),
    .rd_idx (rd_off[AW+1:2]),
    .rd_data(array_rdata)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ar_hs)     state_next = ST_WAIT;
      ST_WAIT: if (wait_done) state_next = ST_RESP;
      ST_RESP: if (r_hs)      state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so arready is low
  // throughout reset and rises on the first edge after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      state_reg   <= state_next;
      rvalid_reg  <= (state_next == ST_RESP);
      arready_reg <= (state_next == ST_IDLE);
      if (ar_hs) begin
        addr_reg <= araddr;
        cnt_reg  <= '0;
      end else if ((state_reg == ST_WAIT) && !wait_done) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (wait_done) begin
        rresp_reg <= fetch_resp;
      end
    end
  end

  // Error responses and idle cycles drive zero; the array output register is
  // not reset, so it is masked here rather than trusted after power-up.
  assign rdata   = (rvalid_reg && (rresp_reg == RESP_OKAY)) ? array_rdata : 32'h0;
  assign rresp   = rresp_reg;
  assign rvalid  = rvalid_reg;
  assign arready = arready_reg;

endmodule
